// File: rtl/usr_sfr_pkg.sv
// Shared definitions for the direct-SFR peripherals: register addresses,
// SCON bit positions and the common UART FSM state type.
package usr_sfr_pkg;

  localparam logic [7:0] DEF_SCON_ADDRS = 8'h98;
  localparam logic [7:0] DEF_SBUF_ADDRS = 8'h99;

  localparam int REN_B = 4;
  localparam int RB8_B = 2;
  localparam int TI_B  = 1;
  localparam int RI_B  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/usr_uart_sfr_bit_timer.sv
// Bit timer: prescaler dividing CPUClock down to 1/16-bit ticks, plus a
// 4-bit tick counter whose wrap marks the end of one bit period.
module uart_bit_timer #(
  parameter int BAUD_DIV = 16
) (
  input  logic       CPUClock,
  input  logic       RESET,
  input  logic       clear,
  output logic       tick_pulse,
  output logic [3:0] tick_count,
  output logic       bit_end
);

  localparam int PW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(BAUD_DIV - 1);

  logic [PW-1:0] prescale;

  always_ff @(posedge CPUClock) begin
    if (RESET || clear) begin
      prescale   <= '0;
      tick_count <= 4'd0;
    end else if (prescale == PRE_MAX) begin
      prescale   <= '0;
      tick_count <= tick_count + 4'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign tick_pulse = (prescale == PRE_MAX);
  assign bit_end    = tick_pulse && (tick_count == 4'd15);

endmodule

// File: rtl/usr_uart_sfr.sv
// 8051-style serial port (SCON/SBUF), mode 1 only: 8N1 asynchronous UART
// on the direct-SFR bus, with RI | TI as a level interrupt request.
module usr_uart_sfr
  import usr_sfr_pkg::*;
#(
  parameter logic [7:0] SCON_ADDRS = DEF_SCON_ADDRS,
  parameter logic [7:0] SBUF_ADDRS = DEF_SBUF_ADDRS,
  parameter int         BAUD_DIV   = 16
) (
  input  logic       CPUClock,
  input  logic       RESET,
  input  logic [7:0] DIR_WR_ADDRS,
  input  logic [7:0] DIR_RD_ADDRS,
  input  logic [7:0] WR_DATA,
  input  logic       DIRECT_WR,
  input  logic       WR_EN,
  output logic [7:0] RD_DATA,
  input  logic       RXD,
  output logic       TXD,
  output logic       UART_INT_REQ
);

  logic       wr_stb, scon_wr, sbuf_wr;
  logic [7:0] scon;
  logic [7:0] sbuf_rx;

  assign wr_stb  = WR_EN & DIRECT_WR;
  assign scon_wr = wr_stb && (DIR_WR_ADDRS == SCON_ADDRS);
  assign sbuf_wr = wr_stb && (DIR_WR_ADDRS == SBUF_ADDRS);

  uart_state_t tx_state, tx_next;
  logic [7:0]  tx_data;
  logic [2:0]  tx_idx;
  logic        tx_clear, tx_done, tx_tick, tx_bit_end, txd_c;
  logic [3:0]  tx_count;
  logic        unused_tx;

  assign unused_tx = ^{tx_tick, tx_count};

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
    .CPUClock  (CPUClock),
    .RESET     (RESET),
    .clear     (tx_clear),
    .tick_pulse(tx_tick),
    .tick_count(tx_count),
    .bit_end   (tx_bit_end)
  );

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      tx_state <= IDLE;
      tx_data  <= 8'h00;
      tx_idx   <= 3'd0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == IDLE && sbuf_wr) begin
        tx_data <= WR_DATA;
        tx_idx  <= 3'd0;
      end else if (tx_state == DATA && tx_bit_end) begin
        tx_idx <= tx_idx + 3'd1;
      end
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_clear = 1'b0;
    tx_done  = 1'b0;
    txd_c    = 1'b1;
    case (tx_state)
      IDLE: begin
        if (sbuf_wr) begin
          tx_next  = START;
          tx_clear = 1'b1;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (tx_bit_end) tx_next = DATA;
      end
      DATA: begin
        txd_c = tx_data[tx_idx];
        if (tx_bit_end && tx_idx == 3'd7) tx_next = STOP;
      end
      STOP: begin
        if (tx_bit_end) begin
          tx_next = IDLE;
          tx_done = 1'b1;
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  assign TXD = txd_c;

  // RXD is asynchronous; only the synchronized copy and its delayed twin are used.
  logic rxd_meta, rxd_sync, rxd_prev, rx_fall;

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign rx_fall = rxd_prev & ~rxd_sync;

  uart_state_t rx_state, rx_next;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_idx;
  logic        rx_clear, rx_done, rx_tick, rx_bit_end;
  logic [3:0]  rx_count;
  logic        rx_s7, rx_s8, rx_decide, rx_maj;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
    .CPUClock  (CPUClock),
    .RESET     (RESET),
    .clear     (rx_clear),
    .tick_pulse(rx_tick),
    .tick_count(rx_count),
    .bit_end   (rx_bit_end)
  );

  assign rx_decide = rx_tick && (rx_count == 4'd9);
  assign rx_maj    = majority3(rx_s7, rx_s8, rxd_sync);

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      rx_state <= IDLE;
      rx_shift <= 8'h00;
      rx_idx   <= 3'd0;
      rx_s7    <= 1'b1;
      rx_s8    <= 1'b1;
    end else begin
      rx_state <= rx_next;
      if (rx_tick && rx_count == 4'd7) rx_s7 <= rxd_sync;
      if (rx_tick && rx_count == 4'd8) rx_s8 <= rxd_sync;
      if (rx_state == IDLE) begin
        rx_idx <= 3'd0;
      end else if (rx_state == DATA) begin
        if (rx_decide) rx_shift <= {rx_maj, rx_shift[7:1]};
        if (rx_bit_end) rx_idx <= rx_idx + 3'd1;
      end
    end
  end

  // REN only gates start detection; a frame already in progress always completes.
  always_comb begin
    rx_next  = rx_state;
    rx_clear = 1'b0;
    rx_done  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_fall && scon[REN_B]) begin
          rx_next  = START;
          rx_clear = 1'b1;
        end
      end
      START: begin
        if (rx_decide && rx_maj) rx_next = IDLE;
        else if (rx_bit_end)     rx_next = DATA;
      end
      DATA: begin
        if (rx_bit_end && rx_idx == 3'd7) rx_next = STOP;
      end
      STOP: begin
        if (rx_decide) begin
          rx_next = IDLE;
          rx_done = 1'b1;
        end
      end
      default: rx_next = IDLE;
    endcase
  end

  // Hardware sets of TI/RI override a simultaneous software write of those bits.
  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      scon    <= 8'h00;
      sbuf_rx <= 8'h00;
    end else begin
      if (scon_wr) scon <= WR_DATA;
      if (tx_done) scon[TI_B] <= 1'b1;
      if (rx_done && !scon[RI_B]) begin
        scon[RI_B] <= 1'b1;
        sbuf_rx    <= rx_shift;
        if (!scon_wr) scon[RB8_B] <= rx_maj;
      end
    end
  end

  always_comb begin
    RD_DATA = 8'h00;
    if (DIR_RD_ADDRS == SCON_ADDRS)      RD_DATA = scon;
    else if (DIR_RD_ADDRS == SBUF_ADDRS) RD_DATA = sbuf_rx;
  end

  assign UART_INT_REQ = scon[TI_B] | scon[RI_B];

endmodule
